bit_serializer: RTL and testbench

Parallel-to-serial stage that accepts WIDTH-bit words on a valid/ready handshake and emits them one bit per cycle as a valid/data stream. Sits directly upstream of the single-bit registered capture stage. o_valid/o_data drive that stage's i_valid/i_data. A one-entry holding register double-buffers the shift register so back-to-back words stream without bubbles.

---
 rtl/bit_serializer_pkg.sv | 19 +
 rtl/bit_serializer.sv | 178 +++++++++++++++++
 tb/tb_bit_serializer.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/bit_serializer_pkg.sv
// Shared types and helpers for the bit serializer.
//   state_t   : serializer FSM states
//   GAP_CNT_W : width of the inter-frame gap counter
//   frame_len : serial frame length in bits (data bits plus optional parity bit)
package bit_serializer_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StGap
    } state_t;

    localparam int unsigned GAP_CNT_W = 4;

    function automatic int unsigned frame_len(input int unsigned width, input bit parity_en);
        return parity_en ? width + 1 : width;
    endfunction

endpackage

// File: rtl/bit_serializer.sv
// Parallel-to-serial stage: accepts WIDTH-bit words on a valid/ready handshake and emits them
// one bit per cycle. A one-entry holding register double-buffers the shifter so back-to-back
// words stream without bubbles.
//
// Optional build macro BIT_SERIALIZER_PARITY_EN: append an even-parity bit to every frame;
// o_last then marks the parity bit.
//
// Ports:
//   i_clk   : clock, posedge
//   i_rst   : synchronous active-high reset
//   i_valid : upstream word valid
//   i_data  : upstream word, sampled on handshake (i_valid && o_ready)
//   o_ready : holding register free
//   o_valid : serial bit valid
//   o_data  : serial bit (0 when o_valid is low)
//   o_last  : final bit of the frame
//   o_busy  : shifter, gap counter or holding register occupied
module bit_serializer
    import bit_serializer_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b0,
    parameter int unsigned GAP       = 0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_ready,
    output logic             o_valid,
    output logic             o_data,
    output logic             o_last,
    output logic             o_busy
);

`ifdef BIT_SERIALIZER_PARITY_EN
    localparam bit ParityEn = 1'b1;
`else
    localparam bit ParityEn = 1'b0;
`endif

    localparam int unsigned Frame = frame_len(WIDTH, ParityEn);
    localparam int unsigned CntW  = $clog2(WIDTH + 1);
    localparam logic [CntW-1:0] FrameLast = CntW'(Frame - 1);
    // Unreachable when GAP is 0; clamped to keep the constant in range.
    localparam logic [GAP_CNT_W-1:0] GapLast = GAP_CNT_W'((GAP == 0) ? 0 : GAP - 1);

    state_t                 state_q, state_d;
    logic [WIDTH-1:0]       hold_q, hold_d;
    logic                   hold_valid_q, hold_valid_d;
    logic [WIDTH-1:0]       shreg_q, shreg_d;
    logic [CntW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [GAP_CNT_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic                   load;
    logic                   hs;
    logic                   shift_bit;
    logic                   data_bit;

    // o_ready comes from registered state only; it stays low in the cycle the hold drains.
    assign o_ready = !hold_valid_q && !i_rst;
    assign hs      = i_valid && o_ready;

    assign shift_bit = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        gap_cnt_d = gap_cnt_q;
        load      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (hold_valid_q) begin
                    load    = 1'b1;
                    state_d = StShift;
                end
            end
            StShift: begin
                if (bit_cnt_q == FrameLast) begin
                    bit_cnt_d = '0;
                    if (GAP != 0) begin
                        gap_cnt_d = '0;
                        state_d   = StGap;
                    end else if (hold_valid_q) begin
                        load = 1'b1;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    shreg_d   = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0}
                                          : {1'b0, shreg_q[WIDTH-1:1]};
                end
            end
            StGap: begin
                if (gap_cnt_q == GapLast) begin
                    gap_cnt_d = '0;
                    if (hold_valid_q) begin
                        load    = 1'b1;
                        state_d = StShift;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        if (load) begin
            shreg_d   = hold_q;
            bit_cnt_d = '0;
        end
    end

    // Load and handshake never coincide: o_ready is low whenever the hold is full.
    always_comb begin
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        if (load) begin
            hold_valid_d = 1'b0;
        end
        if (hs) begin
            hold_d       = i_data;
            hold_valid_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= StIdle;
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
            shreg_q      <= '0;
            bit_cnt_q    <= '0;
            gap_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
            shreg_q      <= shreg_d;
            bit_cnt_q    <= bit_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
        end
    end

`ifdef BIT_SERIALIZER_PARITY_EN
    logic parity_q, parity_d;

    // Parity is captured with the word so the shifter can empty before the parity bit.
    always_comb begin
        parity_d = parity_q;
        if (load) begin
            parity_d = ^hold_q;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= parity_d;
        end
    end

    assign data_bit = (bit_cnt_q == CntW'(WIDTH)) ? parity_q : shift_bit;
`else
    assign data_bit = shift_bit;
`endif

    assign o_valid = (state_q == StShift);
    assign o_data  = o_valid && data_bit;
    assign o_last  = o_valid && (bit_cnt_q == FrameLast);
    assign o_busy  = (state_q != StIdle) || hold_valid_q;

endmodule

// File: tb/tb_bit_serializer.sv
// Bench for bit_serializer: dut0 is LSB-first with no gap, dut1 is MSB-first with GAP=3.
// Expected bits are queued at each handshake and popped as the DUTs emit them; per-cycle logs
// of valid/last/ready/busy/data support the cycle-exact timing checks.
module tb_bit_serializer;

`ifdef BIT_SERIALIZER_PARITY_EN
    localparam int F = 9;
`else
    localparam int F = 8;
`endif
    localparam int LogN = 4096;

    logic       clk = 1'b0;
    logic       rst;
    logic       vld0, vld1;
    logic [7:0] dat0, dat1;
    logic       rdy0, rdy1, v0, v1, d0, d1, l0, l1, b0, b1;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    logic [1:0] sb0[$];
    logic [1:0] sb1[$];

    logic lg_v [0:1][0:LogN-1];
    logic lg_l [0:1][0:LogN-1];
    logic lg_r [0:1][0:LogN-1];
    logic lg_b [0:1][0:LogN-1];
    logic lg_d [0:1][0:LogN-1];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .GAP(0)) u_dut0 (
        .i_clk(clk), .i_rst(rst), .i_valid(vld0), .i_data(dat0), .o_ready(rdy0),
        .o_valid(v0), .o_data(d0), .o_last(l0), .o_busy(b0)
    );

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .GAP(3)) u_dut1 (
        .i_clk(clk), .i_rst(rst), .i_valid(vld1), .i_data(dat1), .o_ready(rdy1),
        .o_valid(v1), .o_data(d1), .o_last(l1), .o_busy(b1)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic observe(input int d, input logic v, input logic dt, input logic l);
        logic [1:0] e;
        if (v) begin
            if ((d == 0 ? sb0.size() : sb1.size()) == 0) begin
                check_eq($sformatf("d%0d_unexpected_bit", d), v, 0);
            end else begin
                e = (d == 0) ? sb0.pop_front() : sb1.pop_front();
                check_eq($sformatf("d%0d_data", d), dt, e[1]);
                check_eq($sformatf("d%0d_last", d), l, e[0]);
            end
        end else begin
            check_eq($sformatf("d%0d_idle_data", d), dt, 0);
            check_eq($sformatf("d%0d_idle_last", d), l, 0);
        end
    endtask

    always @(negedge clk) begin
        if (cyc < LogN) begin
            lg_v[0][cyc] <= v0;   lg_v[1][cyc] <= v1;
            lg_l[0][cyc] <= l0;   lg_l[1][cyc] <= l1;
            lg_r[0][cyc] <= rdy0; lg_r[1][cyc] <= rdy1;
            lg_b[0][cyc] <= b0;   lg_b[1][cyc] <= b1;
            lg_d[0][cyc] <= d0;   lg_d[1][cyc] <= d1;
        end
        observe(0, v0, d0, l0);
        observe(1, v1, d1, l1);
    end

    task automatic push_expected(input int d, input logic [7:0] w);
        logic [1:0] e;
        for (int i = 0; i < 8; i++) begin
            e[1] = (d == 1) ? w[7 - i] : w[i];
            e[0] = (i == F - 1);
            if (d == 0) sb0.push_back(e);
            else        sb1.push_back(e);
        end
`ifdef BIT_SERIALIZER_PARITY_EN
        e = {^w, 1'b1};
        if (d == 0) sb0.push_back(e);
        else        sb1.push_back(e);
`endif
    endtask

    // Called at a negedge; returns at the negedge of the cycle after the handshake.
    task automatic send(input int d, input logic [7:0] w, output int hs);
        int waited = 0;
        if (d == 0) begin vld0 = 1'b1; dat0 = w; end
        else        begin vld1 = 1'b1; dat1 = w; end
        while (!(d == 0 ? rdy0 : rdy1) && waited < 64) begin
            @(negedge clk);
            waited++;
        end
        check_eq($sformatf("d%0d_hs_ready", d), (d == 0) ? rdy0 : rdy1, 1);
        hs = cyc;
        push_expected(d, w);
        @(negedge clk);
        if (d == 0) vld0 = 1'b0;
        else        vld1 = 1'b0;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic check_frame(input int d, input int start, input string tag);
        for (int k = 0; k < F; k++) begin
            check_eq({tag, "_valid"}, lg_v[d][start + k], 1);
            check_eq({tag, "_last"}, lg_l[d][start + k], (k == F - 1) ? 1 : 0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int h1, h2;
        rst = 1'b1;
        vld0 = 1'b0; vld1 = 1'b0;
        dat0 = '0;   dat1 = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_ready0", rdy0, 0);
        check_eq("rst_ready1", rdy1, 0);
        check_eq("rst_valid0", v0, 0);
        check_eq("rst_busy0", b0, 0);
        #1 rst = 1'b0;
        @(negedge clk);
        check_eq("post_rst_ready0", rdy0, 1);
        check_eq("post_rst_ready1", rdy1, 1);
        check_eq("post_rst_busy1", b1, 0);
        check_eq("post_rst_valid1", v1, 0);

        // Single word, latency and drain.
        send(0, 8'hA5, h1);
        wait_until(h1 + F + 3);
        check_eq("single_lat_idle", lg_v[0][h1 + 1], 0);
        check_frame(0, h1 + 2, "single");
        check_eq("single_after", lg_v[0][h1 + 2 + F], 0);
        check_eq("single_busy_off", lg_b[0][h1 + 2 + F], 0);
        check_eq("single_ready_full", lg_r[0][h1 + 1], 0);
        check_eq("single_ready_free", lg_r[0][h1 + 2], 1);

        // Back-to-back, second handshake early: no bubble.
        send(0, 8'hFF, h1);
        send(0, 8'h00, h2);
        check_eq("b2b_hs2_cycle", h2, h1 + 2);
        wait_until(h1 + 2 * F + 4);
        check_frame(0, h1 + 2, "b2b_f1");
        check_frame(0, h1 + 2 + F, "b2b_f2");
        check_eq("b2b_after", lg_v[0][h1 + 2 + 2 * F], 0);
        for (int c = h2 + 1; c <= h1 + 1 + F; c++) check_eq("b2b_ready_full", lg_r[0][c], 0);
        check_eq("b2b_ready_free", lg_r[0][h1 + 2 + F], 1);

        // Second handshake in the last-bit cycle: exactly one idle cycle.
        send(0, 8'h5A, h1);
        wait_until(h1 + 1 + F);
        send(0, 8'hC3, h2);
        check_eq("late_hs2_cycle", h2, h1 + 1 + F);
        wait_until(h2 + F + 4);
        check_frame(0, h1 + 2, "late_f1");
        check_eq("late_bubble", lg_v[0][h2 + 1], 0);
        check_frame(0, h2 + 2, "late_f2");
        check_eq("late_ready_full", lg_r[0][h2 + 1], 0);
        check_eq("late_ready_free", lg_r[0][h2 + 2], 1);

        // MSB-first with GAP=3.
        send(1, 8'h80, h1);
        send(1, 8'h01, h2);
        wait_until(h1 + 2 * F + 10);
        check_frame(1, h1 + 2, "gap_f1");
        for (int c = h1 + 2 + F; c <= h1 + 4 + F; c++) check_eq("gap_idle", lg_v[1][c], 0);
        check_frame(1, h1 + 5 + F, "gap_f2");
        check_eq("gap_after", lg_v[1][h1 + 5 + 2 * F], 0);
        check_eq("gap_busy_tail", lg_b[1][h1 + 5 + 2 * F], 1);
        check_eq("gap_busy_off", lg_b[1][h1 + 8 + 2 * F], 0);
        for (int c = h2 + 1; c <= h1 + 4 + F; c++) check_eq("gap_ready_full", lg_r[1][c], 0);
        check_eq("gap_ready_free", lg_r[1][h1 + 5 + F], 1);

        // Reset during bit 4 of a frame.
        send(0, 8'h3C, h1);
        wait_until(h1 + 6);
        #1 rst = 1'b1;
        sb0.delete();
        sb1.delete();
        @(negedge clk);
        check_eq("abort_valid", v0, 0);
        check_eq("abort_ready", rdy0, 0);
        #1 rst = 1'b0;
        @(negedge clk);
        check_eq("abort_ready_after", rdy0, 1);
        check_eq("abort_busy_after", b0, 0);
        for (int c = h1 + 2; c <= h1 + 7; c++) check_eq("abort_no_last", lg_l[0][c], 0);
        send(0, 8'h01, h2);
        wait_until(h2 + F + 3);
        check_frame(0, h2 + 2, "abort_next");
        check_eq("abort_next_after", lg_v[0][h2 + 2 + F], 0);

`ifdef BIT_SERIALIZER_PARITY_EN
        send(0, 8'h07, h1);
        wait_until(h1 + F + 3);
        check_frame(0, h1 + 2, "par07");
        check_eq("par07_bit", lg_d[0][h1 + 10], 1);
        send(0, 8'h03, h1);
        wait_until(h1 + F + 3);
        check_frame(0, h1 + 2, "par03");
        check_eq("par03_bit", lg_d[0][h1 + 10], 0);
`endif

        repeat (2) @(negedge clk);
        check_eq("sb0_drained", sb0.size(), 0);
        check_eq("sb1_drained", sb1.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
